// File: rtl/endian_load_formatter_pkg.sv
// rtl/endian_load_formatter_pkg.sv - access size type and byte swap / extend helpers
package endian_load_formatter_pkg;

  typedef enum logic [1:0] {SIZE_BYTE, SIZE_HALF, SIZE_WORD, SIZE_DWORD} access_size_t;

  localparam int unsigned MAX_BYTES = 8;

  function automatic logic [3:0] size_bytes(input access_size_t size);
    return 4'd1 << size;
  endfunction

  // Reverses the low nbytes bytes of data; bytes above nbytes come back zero.
  function automatic logic [63:0] swap_bytes_n(input logic [63:0] data, input logic [3:0] nbytes);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < MAX_BYTES; i++) begin
      if (i < int'(nbytes)) r[8*i +: 8] = data[8*(int'(nbytes) - 1 - i) +: 8];
    end
    return r;
  endfunction

  function automatic logic [15:0] swap_bytes_16(input logic [15:0] data);
    logic [63:0] r;
    r = swap_bytes_n({48'd0, data}, 4'd2);
    return r[15:0];
  endfunction

  function automatic logic [31:0] swap_bytes_32(input logic [31:0] data);
    logic [63:0] r;
    r = swap_bytes_n({32'd0, data}, 4'd4);
    return r[31:0];
  endfunction

  // Keeps the low nbytes bytes and fills the rest with zeros or copies of the access MSB.
  function automatic logic [63:0] extend_n(input logic [63:0] data, input logic [3:0] nbytes,
                                           input logic sext);
    logic [63:0] r;
    logic        fill;
    fill = sext & data[8*int'(nbytes) - 1];
    for (int i = 0; i < MAX_BYTES; i++) begin
      r[8*i +: 8] = (i < int'(nbytes)) ? data[8*i +: 8] : {8{fill}};
    end
    return r;
  endfunction

endpackage

// File: rtl/endian_load_formatter_skid.sv
// rtl/endian_load_formatter_skid.sv - two-entry skid buffer (skid_buffer_2), registered in_ready
module skid_buffer_2 #(
  parameter int WIDTH = 33
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  logic             main_valid_q, main_valid_d;
  logic [WIDTH-1:0] main_data_q, main_data_d;
  logic             skid_valid_q, skid_valid_d;
  logic [WIDTH-1:0] skid_data_q, skid_data_d;
  logic             in_ready_q, in_ready_d;
  logic             push, pop;

  always_comb begin
    main_valid_d = main_valid_q;
    main_data_d  = main_data_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    push         = in_valid & in_ready_q;
    pop          = main_valid_q & out_ready;

    if (pop || !main_valid_q) begin
      // Main slot frees up: the older skid entry moves forward first to keep FIFO order.
      if (skid_valid_q) begin
        main_valid_d = 1'b1;
        main_data_d  = skid_data_q;
        skid_valid_d = push;
        if (push) skid_data_d = in_data;
      end else begin
        main_valid_d = push;
        if (push) main_data_d = in_data;
      end
    end else if (push) begin
      skid_valid_d = 1'b1;
      skid_data_d  = in_data;
    end

    in_ready_d = !skid_valid_d;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      main_valid_q <= 1'b0;
      main_data_q  <= '0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      in_ready_q   <= 1'b1;
    end else begin
      main_valid_q <= main_valid_d;
      main_data_q  <= main_data_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      in_ready_q   <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = main_valid_q;
  assign out_data  = main_data_q;

endmodule

// File: rtl/endian_load_formatter.sv
// rtl/endian_load_formatter.sv - load data extract/byte-swap/extend with fault flag and counter
module endian_load_formatter
  import endian_load_formatter_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                              clock,
  input  logic                              reset_n,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [DATA_WIDTH-1:0]             in_data,
  input  logic [1:0]                        in_size,
  input  logic [$clog2(DATA_WIDTH/8)-1:0]   in_offset,
  input  logic                              in_big_endian,
  input  logic                              in_sign_extend,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [DATA_WIDTH-1:0]             out_data,
  output logic                              out_misaligned,
  output logic [COUNT_WIDTH-1:0]            misaligned_count
);

  if (DATA_WIDTH != 32 && DATA_WIDTH != 64) begin : g_bad_width
    $error("endian_load_formatter: DATA_WIDTH must be 32 or 64");
  end

  access_size_t           size;
  logic [3:0]             nbytes;
  logic [63:0]            word64;
  logic [63:0]            shifted;
  logic [63:0]            ordered;
  logic                   fault;
  logic [DATA_WIDTH-1:0]  fmt_data;
  logic [DATA_WIDTH:0]    out_payload;
  logic [COUNT_WIDTH-1:0] count_q, count_d;

  assign size = access_size_t'(in_size);

  always_comb begin
    nbytes  = size_bytes(size);
    word64  = 64'(in_data);
    shifted = word64 >> {in_offset, 3'b000};
    ordered = in_big_endian ? swap_bytes_n(shifted, nbytes) : shifted;
    fault   = ((32'(in_offset) & (32'(nbytes) - 32'd1)) != 32'd0)
            || (size == SIZE_DWORD && DATA_WIDTH == 32);
    // A full-width access has nothing above its MSB, so truncation makes extend a no-op there.
    fmt_data = fault ? '0 : DATA_WIDTH'(extend_n(ordered, nbytes, in_sign_extend));
  end

  skid_buffer_2 #(
    .WIDTH(DATA_WIDTH + 1)
  ) u_skid (
    .clock     (clock),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   ({fault, fmt_data}),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_payload)
  );

  assign out_data       = out_payload[DATA_WIDTH-1:0];
  assign out_misaligned = out_payload[DATA_WIDTH];

  // Faults are counted as they leave, so a dropped (reset) fault is never counted.
  always_comb begin
    count_d = count_q;
    if (out_valid && out_ready && out_misaligned && count_q != '1) count_d = count_q + 1'b1;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) count_q <= '0;
    else          count_q <= count_d;
  end

  assign misaligned_count = count_q;

endmodule

// File: tb/tb_endian_load_formatter.sv
// tb/tb_endian_load_formatter.sv - scoreboard bench for a 32-bit and a 64-bit formatter instance
module tb_endian_load_formatter;

  logic        clock;
  logic        reset_n;
  logic        iv[2];
  logic        ir[2];
  logic [63:0] idata[2];
  logic [1:0]  isz[2];
  logic [2:0]  ioff[2];
  logic        ibe[2];
  logic        isx[2];
  logic        ov[2];
  logic        orr[2];
  logic        om[2];
  logic [31:0] od32;
  logic [63:0] od64;
  logic [1:0]  cnt32;
  logic [15:0] cnt64;
  logic [63:0] od[2];

  int          total;
  int          bad;
  int          cnt_model[2];
  bit          mon_en;
  bit          rnd_on;
  bit          b2b_done;
  bit          rnd_done[2];
  logic [64:0] q0[$];
  logic [64:0] q1[$];

  assign od[0] = {32'd0, od32};
  assign od[1] = od64;

  endian_load_formatter #(.DATA_WIDTH(32), .COUNT_WIDTH(2)) dut32 (
    .clock(clock), .reset_n(reset_n),
    .in_valid(iv[0]), .in_ready(ir[0]), .in_data(idata[0][31:0]), .in_size(isz[0]),
    .in_offset(ioff[0][1:0]), .in_big_endian(ibe[0]), .in_sign_extend(isx[0]),
    .out_valid(ov[0]), .out_ready(orr[0]), .out_data(od32), .out_misaligned(om[0]),
    .misaligned_count(cnt32)
  );

  endian_load_formatter #(.DATA_WIDTH(64), .COUNT_WIDTH(16)) dut64 (
    .clock(clock), .reset_n(reset_n),
    .in_valid(iv[1]), .in_ready(ir[1]), .in_data(idata[1]), .in_size(isz[1]),
    .in_offset(ioff[1]), .in_big_endian(ibe[1]), .in_sign_extend(isx[1]),
    .out_valid(ov[1]), .out_ready(orr[1]), .out_data(od64), .out_misaligned(om[1]),
    .misaligned_count(cnt64)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference: pick bytes by arithmetic, rebuild big-endian by shifting, then widen.
  function automatic logic [64:0] model(input int w, input logic [63:0] din, input int sz,
                                        input int off, input bit be, input bit sx);
    int          nb;
    logic [63:0] d, m, v, r;
    nb = 1 << sz;
    if ((w == 32 && sz == 3) || (off % nb) != 0) return {1'b1, 64'd0};
    d = (w == 32) ? (din & 64'hFFFF_FFFF) : din;
    m = (nb == 8) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (8 * nb)) - 64'd1);
    v = (d >> (8 * off)) & m;
    if (be) begin
      r = '0;
      for (int k = 0; k < nb; k++) r = (r << 8) | ((v >> (8 * k)) & 64'hFF);
      v = r;
    end
    if (sx && nb < 8 && v[8 * nb - 1]) v = v | ~m;
    if (w == 32) v = v & 64'hFFFF_FFFF;
    return {1'b0, v};
  endfunction

  function automatic int qsize(input int i);
    return (i == 0) ? q0.size() : q1.size();
  endfunction

  function automatic logic [64:0] cnt_of(input int i);
    return (i == 0) ? {63'd0, cnt32} : {49'd0, cnt64};
  endfunction

  task automatic check(input string nm, input logic [64:0] act, input logic [64:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic send(input int i, input logic [63:0] d, input int sz, input int off,
                      input bit be, input bit sx);
    int n;
    idata[i] = d;
    isz[i]   = sz[1:0];
    ioff[i]  = off[2:0];
    ibe[i]   = be;
    isx[i]   = sx;
    iv[i]    = 1'b1;
    n = 0;
    forever begin
      @(negedge clock);
      if (ir[i]) break;
      n++;
      if (n > 500) begin
        check("send_timeout", 65'd0, 65'd1);
        iv[i] = 1'b0;
        return;
      end
    end
    if (i == 0) q0.push_back(model(32, d, sz, off, be, sx));
    else        q1.push_back(model(64, d, sz, off, be, sx));
    @(posedge clock);
    #1;
    iv[i] = 1'b0;
  endtask

  task automatic monitor(input int i);
    logic [64:0] held, got, e;
    bit          hv;
    int          cmax;
    hv   = 0;
    cmax = (i == 0) ? 3 : 65535;
    forever begin
      @(negedge clock);
      if (!reset_n || !mon_en) begin
        hv = 0;
        continue;
      end
      check($sformatf("count%0d", i), cnt_of(i), 65'(cnt_model[i]));
      if (ov[i]) begin
        got = {om[i], od[i]};
        if (hv) check($sformatf("hold%0d", i), got, held);
        if (orr[i]) begin
          if (qsize(i) == 0) begin
            check($sformatf("unexpected_out%0d", i), 65'd1, 65'd0);
          end else begin
            e = (i == 0) ? q0.pop_front() : q1.pop_front();
            check($sformatf("out%0d", i), got, e);
            if (e[64] && cnt_model[i] < cmax) cnt_model[i]++;
          end
          hv = 0;
        end else begin
          held = got;
          hv   = 1;
        end
      end
    end
  endtask

  task automatic rand_sends(input int i, input int n);
    int w, sz, off, nb;
    w = (i == 0) ? 32 : 64;
    for (int k = 0; k < n; k++) begin
      sz  = (i == 0) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, 3));
      nb  = 1 << sz;
      off = int'($urandom_range(0, w / 8 - 1));
      if ($urandom_range(0, 2) != 0) off = off & ~(nb - 1);
      send(i, {$urandom, $urandom}, sz, off, 1'($urandom), 1'($urandom));
      if ($urandom_range(0, 3) == 0) idle(1);
    end
    rnd_done[i] = 1;
  endtask

  initial begin
    total = 0;
    bad = 0;
    mon_en = 0;
    rnd_on = 0;
    b2b_done = 0;
    cnt_model[0] = 0;
    cnt_model[1] = 0;
    rnd_done[0] = 0;
    rnd_done[1] = 0;
    for (int i = 0; i < 2; i++) begin
      iv[i] = 0; idata[i] = '0; isz[i] = '0; ioff[i] = '0;
      ibe[i] = 0; isx[i] = 0; orr[i] = 0;
    end
    reset_n = 0;
    fork
      monitor(0);
      monitor(1);
    join_none
    repeat (3) @(posedge clock);
    @(negedge clock);
    #1 reset_n = 1;

    @(negedge clock);
    for (int i = 0; i < 2; i++) begin
      check("rst_in_ready", 65'(ir[i]), 65'd1);
      check("rst_out_valid", 65'(ov[i]), 65'd0);
      check("rst_out_data", 65'(od[i]), 65'd0);
      check("rst_misaligned", 65'(om[i]), 65'd0);
      check("rst_count", cnt_of(i), 65'd0);
    end
    mon_en = 1;
    @(posedge clock);
    #1;
    orr[0] = 1;
    orr[1] = 1;

    // Sign-extended byte, one-cycle latency
    send(0, 64'h8899AABB, 0, 1, 0, 1);
    check("t1_valid", 65'(ov[0]), 65'd1);
    check("t1_data", 65'(od[0]), 65'h0FFFFFFAA);
    check("t1_mis", 65'(om[0]), 65'd0);

    send(0, 64'h11223344, 2, 0, 1, 0);
    check("t2_word_be", 65'(od[0]), 65'h044332211);
    send(0, 64'h11223344, 1, 2, 1, 0);
    check("t2_half_be", 65'(od[0]), 65'h000002211);

    // Fault counted only when it leaves
    idle(3);
    orr[0] = 0;
    send(0, 64'h11223344, 1, 1, 0, 0);
    check("t3_data", 65'(od[0]), 65'd0);
    check("t3_mis", 65'(om[0]), 65'd1);
    idle(3);
    check("t3_count_held", cnt_of(0), 65'd0);
    orr[0] = 1;
    idle(1);
    check("t3_count_out", cnt_of(0), 65'd1);
    send(0, 64'hDEADBEEF, 3, 0, 0, 0);
    check("t3_dword_fault", 65'(om[0]), 65'd1);

    // Backpressure: three back-to-back, only two fit
    idle(3);
    orr[0] = 0;
    fork
      begin
        send(0, {$urandom, $urandom}, 2, 0, 0, 0);
        send(0, {$urandom, $urandom}, 1, 2, 1, 1);
        send(0, {$urandom, $urandom}, 0, 3, 0, 1);
        b2b_done = 1;
      end
    join_none
    idle(5);
    check("t4_in_ready", 65'(ir[0]), 65'd0);
    check("t4_accepted", 65'(qsize(0)), 65'd2);
    orr[0] = 1;
    for (int n = 0; n < 50 && !b2b_done; n++) @(posedge clock);
    if (!b2b_done) check("t4_timeout", 65'd0, 65'd1);
    idle(4);
    check("t4_drained", 65'(qsize(0)), 65'd0);

    // 64-bit dword swap, then reset with entries in flight
    send(1, 64'h0123456789ABCDEF, 3, 0, 1, 0);
    check("t6_dword_be", 65'(od[1]), 65'h0EFCDAB8967452301);
    send(1, 64'h0, 1, 1, 0, 0);
    idle(3);
    check("t6_count_pre", cnt_of(1), 65'd1);
    orr[1] = 0;
    send(1, {$urandom, $urandom}, 2, 4, 0, 1);
    send(1, {$urandom, $urandom}, 1, 6, 1, 0);
    @(posedge clock);
    #2 reset_n = 0;
    #1;
    check("t6_rst_valid64", 65'(ov[1]), 65'd0);
    check("t6_rst_count64", cnt_of(1), 65'd0);
    check("t6_rst_count32", cnt_of(0), 65'd0);
    q0.delete();
    q1.delete();
    cnt_model[0] = 0;
    cnt_model[1] = 0;
    @(negedge clock);
    #1 reset_n = 1;
    orr[1] = 1;
    @(negedge clock);
    check("t6_post_ready", 65'(ir[1]), 65'd1);
    idle(1);

    // Saturation of the 2-bit counter
    for (int k = 0; k < 5; k++) begin
      send(0, {$urandom, $urandom}, 2, 2, 0, 0);
      @(posedge clock);
      #1;
      check($sformatf("t5_sat%0d", k), cnt_of(0), 65'((k + 1 > 3) ? 3 : k + 1));
    end
    idle(3);

    // Random traffic with random backpressure on both instances
    rnd_on = 1;
    fork
      while (rnd_on) begin
        @(posedge clock);
        #1;
        orr[0] = ($urandom_range(0, 3) != 0);
        orr[1] = ($urandom_range(0, 2) != 0);
      end
      rand_sends(0, 150);
      rand_sends(1, 150);
    join_none
    for (int n = 0; n < 5000 && !(rnd_done[0] && rnd_done[1]); n++) @(posedge clock);
    if (!(rnd_done[0] && rnd_done[1])) check("rand_timeout", 65'd0, 65'd1);
    rnd_on = 0;
    @(posedge clock);
    #2;
    orr[0] = 1;
    orr[1] = 1;
    for (int n = 0; n < 200 && (qsize(0) != 0 || qsize(1) != 0); n++) @(posedge clock);
    idle(3);
    check("final_q0_empty", 65'(qsize(0)), 65'd0);
    check("final_q1_empty", 65'(qsize(1)), 65'd0);
    check("final_valid0", 65'(ov[0]), 65'd0);
    check("final_valid1", 65'(ov[1]), 65'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
